// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester, grant and controller signals of the SDRAM port arbiter
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 22
);
  logic                  sdram_ready;
  logic                  sdram_busy;
  logic                  req0;
  logic                  wr0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  req1;
  logic                  wr1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  preempt;
  logic                  abort;
  logic                  sdram_write_enable;
  logic                  sdram_read_enable;
  logic [ADDR_WIDTH-1:0] app_address;

  // Arbiter side.
  modport slave (
    input  sdram_ready, sdram_busy,
    input  req0, wr0, addr0, req1, wr1, addr1,
    output gnt0, gnt1, preempt, abort,
    output sdram_write_enable, sdram_read_enable, app_address
  );

  // Requester / environment side.
  modport master (
    output sdram_ready, sdram_busy,
    output req0, wr0, addr0, req1, wr1, addr1,
    input  gnt0, gnt1, preempt, abort,
    input  sdram_write_enable, sdram_read_enable, app_address
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin owner arbiter for the SDRAM controller command interface
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH       = 22,
  parameter int MAX_GRANT_CYCLES = 1024,
  parameter int CNT_WIDTH        = 10
) (
  input  logic                clk,
  input  logic                rst,
  sdram_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_GRANT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state;
  logic                 owner;
  logic                 last_owner;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 winner;
  logic                 winner_wr;
  logic                 owner_req;
  logic                 other_req;
  logic [CNT_WIDTH-1:0] cnt_next;

  // On a tie the port that did not own the controller last time wins.
  always_comb begin
    winner    = (bus.req0 && bus.req1) ? ~last_owner : bus.req1;
    winner_wr = winner ? bus.wr1 : bus.wr0;
    owner_req = owner ? bus.req1 : bus.req0;
    other_req = owner ? bus.req0 : bus.req1;
    cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= ST_IDLE;
      owner                  <= 1'b0;
      last_owner             <= 1'b1;
      cnt                    <= '0;
      bus.gnt0               <= 1'b0;
      bus.gnt1               <= 1'b0;
      bus.preempt            <= 1'b0;
      bus.abort              <= 1'b0;
      bus.sdram_write_enable <= 1'b0;
      bus.sdram_read_enable  <= 1'b0;
      bus.app_address        <= '0;
    end else begin
      bus.abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.sdram_ready && (bus.req0 || bus.req1)) begin
            owner                  <= winner;
            bus.gnt0               <= ~winner;
            bus.gnt1               <= winner;
            bus.app_address        <= winner ? bus.addr1 : bus.addr0;
            bus.sdram_write_enable <= winner_wr;
            bus.sdram_read_enable  <= ~winner_wr;
            bus.preempt            <= 1'b0;
            cnt                    <= '0;
            state                  <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (!bus.sdram_ready) begin
            // Controller lost: kill the session without crediting the owner.
            bus.gnt0               <= 1'b0;
            bus.gnt1               <= 1'b0;
            bus.sdram_write_enable <= 1'b0;
            bus.sdram_read_enable  <= 1'b0;
            bus.preempt            <= 1'b0;
            bus.abort              <= 1'b1;
            state                  <= ST_IDLE;
          end else if (!owner_req) begin
            bus.gnt0               <= 1'b0;
            bus.gnt1               <= 1'b0;
            bus.sdram_write_enable <= 1'b0;
            bus.sdram_read_enable  <= 1'b0;
            bus.preempt            <= 1'b0;
            last_owner             <= owner;
            state                  <= ST_DRAIN;
          end else begin
            // preempt is sticky and visible in the cycle the quantum expires.
            cnt <= cnt_next;
            if (cnt_next == CNT_MAX && other_req) begin
              bus.preempt <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (!bus.sdram_busy) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized and directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int AW   = 22;
  localparam int MAXG = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          busy;
  logic          req  [2];
  logic          wr   [2];
  logic [AW-1:0] addr [2];

  int tests;
  int fails;

  sdram_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  assign bus.sdram_ready = ready;
  assign bus.sdram_busy  = busy;
  assign bus.req0        = req[0];
  assign bus.wr0         = wr[0];
  assign bus.addr0       = addr[0];
  assign bus.req1        = req[1];
  assign bus.wr1         = wr[1];
  assign bus.addr1       = addr[1];

  sdram_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .MAX_GRANT_CYCLES(MAXG),
    .CNT_WIDTH       (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the controller, whether it is still draining,
  // how many cycles the current owner has held it, and who owned it last.
  int          m_owner;
  bit          m_drain;
  int          m_held;
  bit          m_last;
  bit          m_wr;
  bit          m_pre;
  bit          m_abort;
  logic [AW-1:0] m_addr;
  bit          m_valid = 1'b0;

  function automatic bit port_req(input int p);
    return (p == 1) ? bus.req1 : bus.req0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_drain = 0; m_held = 0; m_last = 1;
      m_wr = 0; m_pre = 0; m_abort = 0; m_addr = '0; m_valid = 1;
    end else if (m_valid) begin
      m_abort = 0;
      if (m_owner >= 0) begin
        if (!bus.sdram_ready) begin
          m_owner = -1;
          m_abort = 1;
        end else if (!port_req(m_owner)) begin
          m_last  = (m_owner == 1);
          m_owner = -1;
          m_drain = 1;
        end else begin
          m_held++;
          if (m_held >= MAXG - 1 && port_req(1 - m_owner)) m_pre = 1;
        end
      end else if (m_drain) begin
        if (!bus.sdram_busy) m_drain = 0;
      end else if (bus.sdram_ready && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) m_owner = m_last ? 0 : 1;
        else                      m_owner = bus.req1 ? 1 : 0;
        m_held = 0;
        m_wr   = (m_owner == 1) ? bus.wr1 : bus.wr0;
        m_addr = (m_owner == 1) ? bus.addr1 : bus.addr0;
      end
      if (m_owner < 0) m_pre = 0;
    end
  end

  logic [27:0] act_vec;
  logic [27:0] exp_vec;

  always @(negedge clk) begin
    if (m_valid) begin
      act_vec = {bus.gnt0, bus.gnt1, bus.preempt, bus.abort,
                 bus.sdram_write_enable, bus.sdram_read_enable, bus.app_address};
      exp_vec = {m_owner == 0, m_owner == 1, m_pre, m_abort,
                 m_owner >= 0 && m_wr, m_owner >= 0 && !m_wr, m_addr};
      chk("model_cmp", {4'd0, act_vec}, {4'd0, exp_vec});
      if ((bus.gnt0 && bus.gnt1) ||
          (bus.sdram_write_enable && bus.sdram_read_enable) ||
          ((bus.sdram_write_enable || bus.sdram_read_enable) && !(bus.gnt0 || bus.gnt1))) begin
        chk("invariant", 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_gnt(input int limit, output int who);
    who = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.gnt0) begin who = 0; break; end
      if (bus.gnt1) begin who = 1; break; end
      tick();
    end
    if (who < 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int who;
  int expw;
  int hold [2];
  int down;
  bit g;

  initial begin
    tests = 0; fails = 0;
    rst = 1; ready = 1; busy = 0;
    req[0] = 1; wr[0] = 1; addr[0] = 22'h012345;
    req[1] = 0; wr[1] = 0; addr[1] = '0;
    hold[0] = 0; hold[1] = 0; down = 0;
    repeat (3) tick();
    chk("reset_outputs", {bus.gnt0, bus.gnt1, bus.preempt, bus.abort,
         bus.sdram_write_enable, bus.sdram_read_enable, bus.app_address}, 32'd0);

    // First grant and frozen session attributes.
    rst = 0;
    chk("gnt0_before_edge", {31'd0, bus.gnt0}, 32'd0);
    tick();
    chk("gnt0_first", {31'd0, bus.gnt0}, 32'd1);
    chk("we_first", {31'd0, bus.sdram_write_enable}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      if (k == 3) begin addr[0] = 22'h3fffff; wr[0] = 0; end
      tick();
      chk("frozen_addr", {10'd0, bus.app_address}, 32'h012345);
      chk("frozen_we", {31'd0, bus.sdram_write_enable}, 32'd1);
    end
    req[0] = 0;
    tick();
    chk("release_gnt0", {31'd0, bus.gnt0}, 32'd0);
    chk("release_en", {30'd0, bus.sdram_write_enable, bus.sdram_read_enable}, 32'd0);

    // Tie alternation after a fresh reset.
    rst = 1; tick(); rst = 0;
    wr[0] = 0; wr[1] = 1; req[0] = 1; req[1] = 1;
    expw = 0;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(20, who);
      chk("alt_order", who, expw);
      chk("alt_dir", {31'd0, bus.sdram_write_enable}, expw);
      tick(); tick();
      if (who >= 0) begin
        req[who] = 0; tick(); req[who] = 1;
      end
      expw = 1 - expw;
    end
    req[0] = 0; req[1] = 0;
    repeat (3) tick();

    // Preemption quantum, then drain with busy held.
    rst = 1; tick(); rst = 0;
    req[0] = 1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) req[1] = 1;
      chk("preempt_cycle", {31'd0, bus.preempt}, (k == 8) ? 32'd1 : 32'd0);
      chk("preempt_gnt0", {31'd0, bus.gnt0}, 32'd1);
      if (k < 8) tick();
    end
    repeat (3) tick();
    chk("advisory_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("preempt_sticky", {31'd0, bus.preempt}, 32'd1);
    req[0] = 0; busy = 1;
    tick();
    chk("preempt_cleared", {30'd0, bus.gnt0, bus.preempt}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("drain_no_gnt1", {31'd0, bus.gnt1}, 32'd0);
    end
    busy = 0;
    tick();
    chk("drain_exit_no_gnt1", {31'd0, bus.gnt1}, 32'd0);
    tick();
    chk("gnt1_after_drain", {31'd0, bus.gnt1}, 32'd1);

    // Abort on sdram_ready loss; last_owner must stay 0 so port 1 wins again.
    req[0] = 1;
    tick();
    ready = 0;
    tick();
    chk("abort_pulse", {31'd0, bus.abort}, 32'd1);
    chk("abort_clear", {27'd0, bus.gnt0, bus.gnt1, bus.preempt,
         bus.sdram_write_enable, bus.sdram_read_enable}, 32'd0);
    tick();
    chk("abort_one_cycle", {31'd0, bus.abort}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("not_ready_no_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    end
    ready = 1;
    wait_gnt(10, who);
    chk("abort_last_owner", who, 1);
    req[0] = 0; req[1] = 0;
    repeat (4) tick();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        g = (p == 1) ? bus.gnt1 : bus.gnt0;
        if (!req[p]) begin
          if ($urandom_range(3) == 0) begin
            req[p]  = 1;
            wr[p]   = 1'($urandom_range(1));
            addr[p] = AW'($urandom);
          end
          hold[p] = 0;
        end else if (g) begin
          if ($urandom_range(7) == 0) begin
            wr[p]   = 1'($urandom_range(1));
            addr[p] = AW'($urandom);
          end
          if (hold[p] == 0) hold[p] = $urandom_range(1, 12);
          else begin
            hold[p]--;
            if (hold[p] == 0) req[p] = 0;
          end
        end else begin
          hold[p] = 0;
        end
      end
      busy = ($urandom_range(2) == 0);
      if (down > 0) begin
        down--;
        ready = (down == 0);
      end else if ($urandom_range(79) == 0) begin
        down  = $urandom_range(1, 5);
        ready = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
